// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter and the
// UART receiver.
//   tx_state_e      - transmitter FSM state (3 bits)
//   UART_DATA_BITS  - data bits per frame
//   *_LEVEL         - serial line levels for start, stop and idle
// Optional build macro: UART_TX_PARITY_EN adds the S_PARITY state.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic START_BIT_LEVEL = 1'b0;
  localparam logic STOP_BIT_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL      = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY  = 3'd3,
`endif
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: divides i_Clock down to the serial bit period.
// The counter runs 0..CLKS_PER_BIT-1 and wraps. o_Bit_Tick is high during
// the last count of each bit, so the owner advances on the wrap edge.
//   i_Clock    - system clock, rising edge
//   i_Reset    - asynchronous active-high reset
//   i_Clear    - holds the count at 0 (no tick while asserted)
//   o_Bit_Tick - high in the final cycle of each bit period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  output logic o_Bit_Tick
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_param
      $error("uart_bit_timer: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   COUNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  assign o_Bit_Tick = !i_Clear && (r_count == COUNT_MAX);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_count <= '0;
    end else if (i_Clear || o_Bit_Tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Sends one byte per accepted request as
// start(0), 8 data bits LSB first, optional even parity, stop(1).
// Each bit lasts CLKS_PER_BIT cycles. No queuing: requests made while
// o_Tx_Ready is low are dropped.
// Handshake: a request is accepted on a rising edge where i_Tx_DV=1 and
// o_Tx_Ready=1; i_Tx_Byte is sampled only on that edge.
//   i_Clock     - system clock, rising edge
//   i_Reset     - asynchronous active-high reset (aborts any frame)
//   i_Tx_DV     - send request
//   i_Tx_Byte   - byte to send
//   o_Tx_Ready  - high in IDLE
//   o_Tx_Active - high from start bit through stop bit
//   o_Tx_Serial - registered serial line, idles high
//   o_Tx_Done   - one-cycle pulse after the stop bit
// Optional build macro: UART_TX_PARITY_EN (adds even parity bit).
// The FSM state is held in r_state for debug/checker visibility.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  tx_state_e                 r_state, w_next_state;
  logic [UART_DATA_BITS-1:0] r_shift, w_next_shift;
  logic [2:0]                r_index, w_next_index;
  logic                      r_serial, w_next_serial;
  logic                      r_active, w_next_active;
  logic                      r_done, w_next_done;
  logic                      w_bit_tick;
  logic                      w_timer_clear;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity, w_next_parity;
`endif

  // Timer is parked at 0 outside a frame so the start bit gets a full period.
  assign w_timer_clear = (r_state == S_IDLE) || (r_state == S_CLEANUP);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Clear    (w_timer_clear),
    .o_Bit_Tick (w_bit_tick)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_index  <= '0;
      r_serial <= IDLE_LEVEL;
      r_active <= 1'b0;
      r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_next_state;
      r_shift  <= w_next_shift;
      r_index  <= w_next_index;
      r_serial <= w_next_serial;
      r_active <= w_next_active;
      r_done   <= w_next_done;
`ifdef UART_TX_PARITY_EN
      r_parity <= w_next_parity;
`endif
    end
  end

  // The serial register is loaded with the level of the *next* bit on the
  // edge that enters it, so the line changes exactly on bit boundaries.
  always_comb begin
    w_next_state  = r_state;
    w_next_shift  = r_shift;
    w_next_index  = r_index;
    w_next_serial = r_serial;
    w_next_active = r_active;
    w_next_done   = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_next_parity = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_next_serial = IDLE_LEVEL;
        w_next_active = 1'b0;
        if (i_Tx_DV) begin
          w_next_shift  = i_Tx_Byte;
          w_next_index  = '0;
          w_next_state  = S_START;
          w_next_serial = START_BIT_LEVEL;
          w_next_active = 1'b1;
`ifdef UART_TX_PARITY_EN
          w_next_parity = ^i_Tx_Byte;
`endif
        end
      end
      S_START: begin
        if (w_bit_tick) begin
          w_next_state  = S_DATA;
          w_next_index  = '0;
          w_next_serial = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_tick) begin
          if (r_index == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            w_next_state  = S_PARITY;
            w_next_serial = r_parity;
`else
            w_next_state  = S_STOP;
            w_next_serial = STOP_BIT_LEVEL;
`endif
          end else begin
            w_next_index  = r_index + 3'd1;
            w_next_shift  = {1'b0, r_shift[UART_DATA_BITS-1:1]};
            w_next_serial = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_tick) begin
          w_next_state  = S_STOP;
          w_next_serial = STOP_BIT_LEVEL;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_tick) begin
          w_next_state  = S_CLEANUP;
          w_next_serial = IDLE_LEVEL;
          w_next_active = 1'b0;
          w_next_done   = 1'b1;
        end
      end
      S_CLEANUP: begin
        w_next_state  = S_IDLE;
        w_next_serial = IDLE_LEVEL;
      end
      default: begin
        w_next_state  = S_IDLE;
        w_next_serial = IDLE_LEVEL;
        w_next_active = 1'b0;
      end
    endcase
  end

  assign o_Tx_Ready  = (r_state == S_IDLE);
  assign o_Tx_Active = r_active;
  assign o_Tx_Serial = r_serial;
  assign o_Tx_Done   = r_done;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serialises one 8-bit byte per request as 1 start bit (0), 8 data bits LSB first, an optional parity bit, and 1 stop bit (1). No flow control.
- Sits beside the existing UART receiver on the same i_Clock and uses the same CLKS_PER_BIT timing, so the two loop back directly.
- Supplies the FPGA-to-host direction of the serial link.

Parameters:
- CLKS_PER_BIT, 217, i_Clock cycles per serial bit (i_Clock frequency / baud). Legal range ≥ 2; the build fails on smaller values.

Ports:
- i_Clock  in  1  system clock; all logic on the rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Tx_DV  in  1  request: send i_Tx_Byte. Accepted only while o_Tx_Ready=1.
- i_Tx_Byte  in  8  byte to send; sampled on the accept edge only.
- o_Tx_Ready  out  1  high in IDLE; the block can accept a request.
- o_Tx_Active  out  1  high while a frame is on the line (start through stop).
- o_Tx_Serial  out  1  serial line, registered; idle level 1.
- o_Tx_Done  out  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (asynchronous, i_Reset=1):
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1.
  - State=IDLE; counters and shift register cleared.
  - Reset mid-frame aborts the frame immediately. The line returns high with no partial stop bit.
- States: IDLE, START, DATA, [PARITY], STOP, CLEANUP.
- IDLE:
  - o_Tx_Ready=1.
  - Accept edge = a rising edge with i_Tx_DV=1. On that edge: latch i_Tx_Byte, clear the bit counter, move to START, o_Tx_Serial<=0, o_Tx_Active<=1.
- Bit timing: every bit is held on o_Tx_Serial for exactly CLKS_PER_BIT cycles. The counter runs 0..CLKS_PER_BIT-1, wraps to 0, and the state or bit index advances on that wrap edge.
- START: drive 0; on wrap go to DATA with bit index 0.
- DATA:
  - Drive byte[index]. On wrap, index increments.
  - After index 7 completes: go to PARITY if compiled in, else STOP.
  - Index is 3 bits and must not wrap back into DATA.
- STOP: drive 1. On wrap go to CLEANUP, o_Tx_Active<=0, o_Tx_Done<=1.
- CLEANUP:
  - Lasts exactly one cycle; o_Tx_Done is high for that cycle only.
  - o_Tx_Serial stays 1, o_Tx_Ready=0. Next state IDLE.
- Requests outside IDLE:
  - i_Tx_DV while not ready is ignored; no queuing.
  - i_Tx_Byte changes during a frame do not affect the frame.
- Line-low latency: o_Tx_Serial goes low in the cycle directly after the accept edge.
- Throughput: with i_Tx_DV held high, accept-to-accept spacing is exactly 10*CLKS_PER_BIT+2 cycles (11*CLKS_PER_BIT+2 with parity).
- Default state encoding → IDLE with line high.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - PARITY state inserted after DATA, held CLKS_PER_BIT cycles.
  - Parity bit = XOR of the 8 latched data bits (even parity).
- UART_TX_PARITY_EN undefined: no PARITY state, no parity logic; the frame is 10 bits.

Decomposition:
- Package uart_pkg holds:
  - the tx state enum (3 bits);
  - UART_DATA_BITS=8, START_BIT_LEVEL=0, STOP_BIT_LEVEL=1, IDLE_LEVEL=1.
- Counter width is $clog2(CLKS_PER_BIT), computed locally.
- One natural sub-module: uart_bit_timer.
  - Parameter CLKS_PER_BIT; inputs i_Clock, i_Reset, i_Clear; output o_Bit_Tick, which pulses on the count wrap.
  - Later reusable by the receiver.

Test Plan:
- CLKS_PER_BIT=4, send 0xA5 → line 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - o_Tx_Done pulses once, 41 cycles after the accept edge.
  - o_Tx_Active high for 40 cycles.
- Pulse i_Tx_DV with 0x3C mid-frame of 0xA5 → ignored; only 0xA5 is sent and o_Tx_Done pulses once.
- Hold i_Tx_DV=1 with bytes 0x00 then 0xFF → two frames; accepts are exactly 42 cycles apart; line high between frames.
- Assert i_Reset during DATA bit 3 of 0x55 → o_Tx_Serial=1 and o_Tx_Active=0 asynchronously; next request 0x81 is sent intact.
- UART_TX_PARITY_EN, CLKS_PER_BIT=4:
  - 0xA5 → parity bit 0; 0x01 → parity bit 1.
  - Frame is 44 cycles; o_Tx_Done is 45 cycles after accept.
- Loopback to the receiver at CLKS_PER_BIT=217, bytes 0x00, 0xFF, 0xA5, 0x5A → receiver outputs the same bytes with one o_Rx_DV each.
